// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, ACK polarity, target FSM encoding and a
// majority-vote helper used by the bus input filter.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int BIT_CNT_W  = 3;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Register-bus between the I2C target and external register storage.
// master = the I2C target, slave = the register file answering it.
interface i2c_target_if #(
  parameter int PTR_W = 8
);
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic             busy;

  modport master (output wr_valid, wr_addr, wr_data, rd_addr, busy, input rd_data);
  modport slave  (input wr_valid, wr_addr, wr_data, rd_addr, busy, output rd_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into clk and derives SCL edges plus START/STOP.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronisers.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_f;
  logic sda_f;
  logic scl_q;
  logic sda_q;

  // Idle bus is high, so reset to 1 to avoid phantom edges on reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
      scl_f    <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
      sda_f    <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
    end
  end
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign sda_s     = sda_f;
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, register pointer, byte writes/reads onto a simple reg bus.
// Optional input glitch filter via I2C_TARGET_GLITCH_FILTER_EN (see i2c_bus_sync).
//
// state        | meaning
// IDLE         | bus free or after STOP
// ADDR         | shifting {addr,rw}
// ADDR_ACK     | acknowledging our address
// PTR          | shifting register pointer byte
// PTR_ACK      | acknowledging pointer byte
// WDATA        | shifting write data byte
// WDATA_ACK    | acknowledging write data byte
// RDATA        | driving read data byte
// RDATA_ACK    | sampling master ACK/NACK
// IGNORE       | not addressed / read ended; wait for START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42,
  parameter int                    PTR_W       = 8,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i2c_scl,
  inout  wire          i2c_sda,
  i2c_target_if.master reg_bus
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_raw   (i2c_scl),
    .sda_raw   (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t             state, state_n;
  logic [I2C_BYTE_W-1:0]  shreg, shreg_n;
  logic [BIT_CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]       ptr, ptr_n;
  logic                   sda_oe, sda_oe_n;
  logic                   rw, rw_n;
  logic                   wr_valid, wr_valid_n;
  logic [PTR_W-1:0]       wr_addr, wr_addr_n;
  logic [I2C_BYTE_W-1:0]  wr_data, wr_data_n;
  logic                   busy, busy_n;
  logic [I2C_BYTE_W-1:0]  byte_in;
  logic                   addr_hit;

  assign byte_in  = {shreg[I2C_BYTE_W-2:0], sda_s};
  assign addr_hit = (byte_in[7:1] == TARGET_ADDR) && (byte_in[7:1] != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '1;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      rw       <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      sda_oe   <= sda_oe_n;
      rw       <= rw_n;
      wr_valid <= wr_valid_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    ptr_n      = ptr;
    sda_oe_n   = sda_oe;
    rw_n       = rw;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    busy_n     = busy;

    // Post-write pointer bump lands one clk after the wr_valid pulse.
    if (wr_valid) ptr_n = ptr + PTR_W'(1);

    if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n  = ST_ADDR;
      cnt_n    = '1;
      sda_oe_n = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == '0) begin
            if (addr_hit) begin
              state_n = ST_ADDR_ACK;
              rw_n    = byte_in[0];
              busy_n  = 1'b1;
            end else begin
              state_n = ST_IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ST_PTR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == '0) begin
            ptr_n   = PTR_W'(byte_in);
            state_n = ST_PTR_ACK;
          end
        end
        ST_WDATA: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt - 3'd1;
          if (cnt == '0) begin
            wr_valid_n = 1'b1;
            wr_addr_n  = ptr;
            wr_data_n  = byte_in;
            state_n    = ST_WDATA_ACK;
          end
        end
        // First fall after the byte starts the ACK, the next one ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            sda_oe_n = 1'b0;
            cnt_n    = '1;
            if (state == ST_ADDR_ACK && rw) begin
              state_n  = ST_RDATA;
              shreg_n  = reg_bus.rd_data;
              sda_oe_n = ~reg_bus.rd_data[7];
            end else if (state == ST_ADDR_ACK) begin
              state_n = ST_PTR;
            end else begin
              state_n = ST_WDATA;
            end
          end
        end
        // shreg[7] is the bit currently on the bus.
        ST_RDATA: if (scl_fall) begin
          if (cnt == '0) begin
            sda_oe_n = 1'b0;
            state_n  = ST_RDATA_ACK;
            ptr_n    = ptr + PTR_W'(1);
          end else begin
            shreg_n  = {shreg[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_n = ~shreg[6];
            cnt_n    = cnt - 3'd1;
          end
        end
        // NACK ends the read at the rise; after an ACK the next byte starts at the fall.
        ST_RDATA_ACK: begin
          if (scl_rise && sda_s == NACK) begin
            state_n = ST_IGNORE;
          end else if (scl_fall) begin
            state_n  = ST_RDATA;
            shreg_n  = reg_bus.rd_data;
            sda_oe_n = ~reg_bus.rd_data[7];
            cnt_n    = '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  assign reg_bus.wr_valid = wr_valid;
  assign reg_bus.wr_addr  = wr_addr;
  assign reg_bus.wr_data  = wr_data;
  assign reg_bus.rd_addr  = ptr;
  assign reg_bus.busy     = busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master with pull-ups, register model rd_data = ~rd_addr.
module tb_i2c_target;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic scl_rel, sda_rel;
  wire  i2c_scl;
  wire  i2c_sda;

  int errors = 0;
  int checks = 0;
  int dut_low = 0;
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  assign i2c_scl = scl_rel ? 1'bz : 1'b0;
  assign i2c_sda = sda_rel ? 1'bz : 1'b0;
  pullup (i2c_scl);
  pullup (i2c_sda);

  i2c_target_if #(.PTR_W(8)) rb ();
  assign rb.rd_data = ~rb.rd_addr;

  i2c_target #(.TARGET_ADDR(7'h42), .PTR_W(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i2c_scl (i2c_scl),
    .i2c_sda (i2c_sda),
    .reg_bus (rb)
  );

  always @(negedge clk) begin
    if (rb.wr_valid) wq.push_back({rb.wr_addr, rb.wr_data});
    if (sda_rel && i2c_sda === 1'b0) dut_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] qget(input int k);
    if (k < wq.size()) return wq[k];
    return 16'hxxxx;
  endfunction

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_rel = 1'b1; wt(5);
    scl_rel = 1'b1; wt(10);
    sda_rel = 1'b0; wt(10);
    scl_rel = 1'b0;
  endtask

  task automatic m_stop();
    sda_rel = 1'b0; wt(5);
    scl_rel = 1'b1; wt(10);
    sda_rel = 1'b1; wt(10);
  endtask

  task automatic m_bit(input logic b, output logic r);
    wt(5); sda_rel = b;
    wt(5); scl_rel = 1'b1;
    wt(5); r = i2c_sda;
    wt(5); scl_rel = 1'b0;
  endtask

  // Same as m_bit but with a 1-clk scl pulse while scl is low.
  task automatic m_bit_glitch(input logic b, output logic r);
    wt(5); sda_rel = b;
    wt(2); scl_rel = 1'b1;
    wt(1); scl_rel = 1'b0;
    wt(2); scl_rel = 1'b1;
    wt(5); r = i2c_sda;
    wt(5); scl_rel = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] d, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) m_bit(d[i], x);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(input logic nack, output logic [7:0] d);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, x);
      d[i] = x;
    end
    m_bit(nack, x);
  endtask

  initial begin
    logic       ack, x;
    logic [7:0] rd;
    int         base, low0;
    logic [7:0] gbyte;

    scl_rel = 1'b1;
    sda_rel = 1'b1;
    reset_n = 1'b0;
    wt(4);
    chk("rst_wr_valid", 32'(rb.wr_valid), 32'd0);
    chk("rst_wr_addr",  32'(rb.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(rb.wr_data),  32'd0);
    chk("rst_rd_addr",  32'(rb.rd_addr),  32'd0);
    chk("rst_busy",     32'(rb.busy),     32'd0);
    chk("rst_sda",      32'(i2c_sda),     32'd1);
    chk("rst_state",    32'(dut.state),   32'(ST_IDLE));
    reset_n = 1'b1;
    wt(10);

    // 1: pointer 0x05, two data bytes
    base = wq.size();
    m_start();
    m_byte(8'h84, ack); chk("t1_ack_addr", 32'(ack), 32'd0);
    m_byte(8'h05, ack); chk("t1_ack_ptr",  32'(ack), 32'd0);
    m_byte(8'hA5, ack); chk("t1_ack_d0",   32'(ack), 32'd0);
    m_byte(8'h5A, ack); chk("t1_ack_d1",   32'(ack), 32'd0);
    chk("t1_busy_on", 32'(rb.busy), 32'd1);
    m_stop();
    chk("t1_busy_off", 32'(rb.busy), 32'd0);
    chk("t1_wr_count", 32'(wq.size() - base), 32'd2);
    chk("t1_wr0", 32'(qget(base)),     32'h05A5);
    chk("t1_wr1", 32'(qget(base + 1)), 32'h065A);
    chk("t1_rd_addr", 32'(rb.rd_addr), 32'h07);

    // 2: pointer 0x10, repeated START, read three bytes
    base = wq.size();
    m_start();
    m_byte(8'h84, ack); chk("t2_ack_addr", 32'(ack), 32'd0);
    m_byte(8'h10, ack); chk("t2_ack_ptr",  32'(ack), 32'd0);
    m_start();
    m_byte(8'h85, ack); chk("t2_ack_raddr", 32'(ack), 32'd0);
    m_read(1'b0, rd); chk("t2_rd0", 32'(rd), 32'hEF);
    m_read(1'b0, rd); chk("t2_rd1", 32'(rd), 32'hEE);
    m_read(1'b1, rd); chk("t2_rd2", 32'(rd), 32'hED);
    chk("t2_state_nack", 32'(dut.state), 32'(ST_IGNORE));
    m_stop();
    chk("t2_rd_addr", 32'(rb.rd_addr), 32'h13);
    chk("t2_no_write", 32'(wq.size() - base), 32'd0);

    // 3: foreign address 0x43, then general call
    base = wq.size();
    low0 = dut_low;
    m_start();
    m_byte(8'h86, ack); chk("t3_nack_addr", 32'(ack), 32'd1);
    chk("t3_state_ign", 32'(dut.state), 32'(ST_IGNORE));
    chk("t3_busy", 32'(rb.busy), 32'd0);
    m_byte(8'hFF, ack); chk("t3_nack_data", 32'(ack), 32'd1);
    chk("t3_state_ign2", 32'(dut.state), 32'(ST_IGNORE));
    m_stop();
    chk("t3_state_idle", 32'(dut.state), 32'(ST_IDLE));
    m_start();
    m_byte(8'h00, ack); chk("t3_gencall_nack", 32'(ack), 32'd1);
    m_stop();
    chk("t3_sda_never_low", 32'(dut_low - low0), 32'd0);
    chk("t3_no_write", 32'(wq.size() - base), 32'd0);

    // 4: pointer wrap
    base = wq.size();
    m_start();
    m_byte(8'h84, ack);
    m_byte(8'hFF, ack);
    m_byte(8'h11, ack); chk("t4_ack_d0", 32'(ack), 32'd0);
    m_byte(8'h22, ack); chk("t4_ack_d1", 32'(ack), 32'd0);
    m_stop();
    chk("t4_wr0", 32'(qget(base)),     32'hFF11);
    chk("t4_wr1", 32'(qget(base + 1)), 32'h0022);
    chk("t4_rd_addr", 32'(rb.rd_addr), 32'h01);

    // 5a: STOP after four data bits
    base = wq.size();
    m_start();
    m_byte(8'h84, ack);
    m_byte(8'h30, ack);
    m_bit(1'b1, x); m_bit(1'b1, x); m_bit(1'b0, x); m_bit(1'b0, x);
    m_stop();
    chk("t5_stop_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t5_stop_busy", 32'(rb.busy), 32'd0);
    chk("t5_stop_sda", 32'(i2c_sda), 32'd1);
    chk("t5_stop_nowr", 32'(wq.size() - base), 32'd0);
    chk("t5_stop_ptr", 32'(rb.rd_addr), 32'h30);

    // 5b: reset while the target drives the address ACK
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(((8'h84 >> i) & 8'h01) != 8'h00, x);
    wt(5); sda_rel = 1'b1;
    wt(5); scl_rel = 1'b1;
    wt(5);
    chk("t5_ack_driven", 32'(i2c_sda), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_sda", 32'(i2c_sda), 32'd1);
    chk("t5_rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t5_rst_ptr", 32'(rb.rd_addr), 32'h00);
    wt(3);
    reset_n = 1'b1;
    wt(15);
    m_start();
    m_byte(8'h84, ack); chk("t5_after_rst_ack", 32'(ack), 32'd0);
    m_stop();
    chk("t5_nowr_total", 32'(wq.size() - base), 32'd0);

    // 6: 1-clk scl glitch during data byte 0x96 (glitch on bit 4)
    base = wq.size();
    gbyte = 8'h96;
    m_start();
    m_byte(8'h84, ack);
    m_byte(8'h40, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) m_bit_glitch(gbyte[i], x);
      else        m_bit(gbyte[i], x);
    end
    m_bit(1'b1, ack);
    m_stop();
    chk("t6_wr_count", 32'(wq.size() - base), 32'd1);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk("t6_wr_filtered", 32'(qget(base)), 32'h4096);
    chk("t6_ack_filtered", 32'(ack), 32'd0);
`else
    chk("t6_wr_glitched", 32'(qget(base)), 32'h409B);
    chk("t6_ack_glitched", 32'(ack), 32'd1);
`endif
    chk("t6_rd_addr", 32'(rb.rd_addr), 32'h41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
